// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and ready
// is low; ready never depends on the same side's valid.
//
// Stage S1 captures {a, b, op}. Stage S2 captures the computed result and
// flags, which drive the outputs directly from registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   in_valid   operands/op valid            in_ready   S1 can accept this cycle
//   a, b       operands (b[SHW-1:0] = shift amount for shift ops)
//   op         4-bit opcode
//   out_valid  result/flags valid           out_ready  consumer accepts result
//   result     WIDTH-bit result
//   carry_out  C flag   zero  Z flag   negative  N flag   overflow  V flag
//   err        illegal opcode (13..15)
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_NOT  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;

    // S1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;

    // S2 state (s2_valid drives out_valid; result/flags are the output regs)
    logic             s2_valid;
    logic             cflag;

    logic s1_adv;
    assign s1_adv    = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s1_adv;
    assign out_valid = s2_valid;

    // Combinational execute on S1 contents
    logic [SHW-1:0]   sh;
    logic             sub_op;
    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] fval_c;   // value Z/N are derived from (differs for CMP)
    logic             c_c;
    logic             v_c;
    logic             e_c;
    logic             arith_c;  // op updates cflag and may set V

    always_comb begin
        sh     = s1_b[SHW-1:0];
        sub_op = (s1_op == OP_SUB) || (s1_op == OP_SBC) || (s1_op == OP_CMP);
        b_eff  = sub_op ? ~s1_b : s1_b;
        case (s1_op)
            OP_SUB, OP_CMP: cin = 1'b1;
            OP_ADC, OP_SBC: cin = cflag;
            default:        cin = 1'b0;
        endcase
        sum_w = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        // Shifts are done one bit wider so the bit shifted out lands in a
        // fixed position: bit WIDTH for left, bit 0 for right. With s==0
        // that position holds the zero padding, giving C=0.
        shl_w = {1'b0, s1_a} << sh;
        shr_w = {s1_a, 1'b0} >> sh;
        sra_w = $unsigned($signed({s1_a, 1'b0}) >>> sh);

        arith_c = 1'b0;
        e_c     = 1'b0;
        c_c     = 1'b0;
        res_c   = '0;
        case (s1_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res_c   = sum_w[WIDTH-1:0];
                c_c     = sum_w[WIDTH];
                arith_c = 1'b1;
            end
            OP_CMP: begin
                res_c   = s1_a;
                c_c     = sum_w[WIDTH];
                arith_c = 1'b1;
            end
            OP_AND:  res_c = s1_a & s1_b;
            OP_OR:   res_c = s1_a | s1_b;
            OP_XOR:  res_c = s1_a ^ s1_b;
            OP_SHL: begin
                res_c = shl_w[WIDTH-1:0];
                c_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_c = shr_w[WIDTH:1];
                c_c   = shr_w[0];
            end
            OP_SRA: begin
                res_c = sra_w[WIDTH:1];
                c_c   = sra_w[0];
            end
            OP_PASS: res_c = s1_b;
            OP_NOT:  res_c = ~s1_a;
            default: e_c = 1'b1;
        endcase

        fval_c = (s1_op == OP_CMP) ? sum_w[WIDTH-1:0] : res_c;
        // Signed overflow: operands agree in sign but the sum does not.
        v_c = arith_c & (s1_a[WIDTH-1] == b_eff[WIDTH-1]) &
              (sum_w[WIDTH-1] != s1_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s2_valid  <= 1'b0;
            cflag     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_a     <= a;
                s1_b     <= b;
                s1_op    <= op;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid  <= 1'b1;
                result    <= res_c;
                carry_out <= c_c;
                zero      <= ~e_c & (fval_c == '0);
                negative  <= ~e_c & fval_c[WIDTH-1];
                overflow  <= v_c;
                err       <= e_c;
                if (arith_c) cflag <= c_c;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule
